writeback_arbiter: RTL and testbench

Merges the single-cycle pipeline writeback path and long-latency results (divider, multi-cycle loads) onto the register file's single write port. Sits directly upstream of the register file and drives its write address, enable and value. Buffers long-latency results in a small FIFO and keeps a per-register busy scoreboard so decode can stall on pending long-latency destinations.

---
 rtl/writeback_arbiter_pkg.sv | 19 +
 rtl/wb_ll_fifo.sv | 59 +++++
 rtl/writeback_arbiter.sv | 109 ++++++++++
 tb/tb_writeback_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and the writeback entry payload used by the arbiter and its
// long-latency result FIFO.
package writeback_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_REGS  = 1 << REG_IDX_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    value;
  } wb_entry_t;

  // x0 is never written and never marked busy.
  function automatic logic is_real_rd(input logic [REG_IDX_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Synchronous FIFO for long-latency writeback entries; head is visible
// combinationally so the arbiter can pop and present it in the same cycle.
module wb_ll_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   SYS_clk,
  input  logic                   SYS_reset,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = count == CNT_W'(DEPTH);
  assign empty_c = count == '0;
  assign head_c  = mem[rd_ptr];

  // Overflow and underflow requests are silently ignored.
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge SYS_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline and long-latency writebacks onto the single register-file
// write port and tracks pending long-latency destinations for decode.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned LL_FIFO_DEPTH = 2
) (
  input  logic                           SYS_clk,
  input  logic                           SYS_reset,
  input  logic                           PIPE_wb_valid,
  input  logic [REG_IDX_W-1:0]           PIPE_wb_rd,
  input  logic [DATA_W-1:0]              PIPE_wb_value,
  input  logic                           LL_issue_valid,
  input  logic [REG_IDX_W-1:0]           LL_issue_rd,
  input  logic                           LL_result_valid,
  input  logic [REG_IDX_W-1:0]           LL_result_rd,
  input  logic [DATA_W-1:0]              LL_result_value,
  output logic                           LL_result_ready,
  input  logic [REG_IDX_W-1:0]           SB_query_rs1,
  input  logic [REG_IDX_W-1:0]           SB_query_rs2,
  output logic                           SB_rs1_busy,
  output logic                           SB_rs2_busy,
  output logic [REG_IDX_W-1:0]           REG_write_address,
  output logic                           REG_write_enable,
  output logic [DATA_W-1:0]              REG_write_value,
  output logic [$clog2(LL_FIFO_DEPTH):0] LL_fifo_count
);

  wb_entry_t           push_data;
  wb_entry_t           head_c;
  logic                full_c;
  logic                empty_c;
  logic                push;
  logic                pop;
  logic                pipe_take;
  logic                write_from_ll;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Ready is gated by reset so upstream never hands off into a clearing FIFO.
  assign LL_result_ready = SYS_reset && !full_c;
  assign push            = LL_result_valid && LL_result_ready;
  assign push_data       = '{rd: LL_result_rd, value: LL_result_value};

  // Pipeline writes to x0 are dropped and leave the port free for the FIFO.
  assign pipe_take = PIPE_wb_valid && is_real_rd(PIPE_wb_rd);
  assign pop       = !pipe_take && !empty_c;

  wb_ll_fifo #(
    .DEPTH (LL_FIFO_DEPTH)
  ) u_ll_fifo (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_c    (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .count     (LL_fifo_count)
  );

  // Register-file write port; address and value hold when idle.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      REG_write_address <= '0;
      REG_write_enable  <= 1'b0;
      REG_write_value   <= '0;
      write_from_ll     <= 1'b0;
    end else begin
      write_from_ll <= pop;
      if (pipe_take) begin
        REG_write_address <= PIPE_wb_rd;
        REG_write_enable  <= 1'b1;
        REG_write_value   <= PIPE_wb_value;
      end else if (pop) begin
        REG_write_address <= head_c.rd;
        REG_write_enable  <= is_real_rd(head_c.rd);
        REG_write_value   <= head_c.value;
      end else begin
        REG_write_enable  <= 1'b0;
      end
    end
  end

  // Clear on register-file commit of an LL write; a same-cycle issue wins.
  always_comb begin
    busy_next = busy;
    if (write_from_ll) begin
      busy_next[REG_write_address] = 1'b0;
    end
    if (LL_issue_valid) begin
      busy_next[LL_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign SB_rs1_busy = busy[SB_query_rs1];
  assign SB_rs2_busy = busy[SB_query_rs2];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector table, a reset-mid-operation sequence, and randomized
// traffic compared against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        PIPE_wb_valid;
  logic [4:0]  PIPE_wb_rd;
  logic [31:0] PIPE_wb_value;
  logic        LL_issue_valid;
  logic [4:0]  LL_issue_rd;
  logic        LL_result_valid;
  logic [4:0]  LL_result_rd;
  logic [31:0] LL_result_value;
  logic        LL_result_ready;
  logic [4:0]  SB_query_rs1;
  logic [4:0]  SB_query_rs2;
  logic        SB_rs1_busy;
  logic        SB_rs2_busy;
  logic [4:0]  REG_write_address;
  logic        REG_write_enable;
  logic [31:0] REG_write_value;
  logic [1:0]  LL_fifo_count;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter #(.LL_FIFO_DEPTH(DEPTH)) dut (
    .SYS_clk           (SYS_clk),
    .SYS_reset         (SYS_reset),
    .PIPE_wb_valid     (PIPE_wb_valid),
    .PIPE_wb_rd        (PIPE_wb_rd),
    .PIPE_wb_value     (PIPE_wb_value),
    .LL_issue_valid    (LL_issue_valid),
    .LL_issue_rd       (LL_issue_rd),
    .LL_result_valid   (LL_result_valid),
    .LL_result_rd      (LL_result_rd),
    .LL_result_value   (LL_result_value),
    .LL_result_ready   (LL_result_ready),
    .SB_query_rs1      (SB_query_rs1),
    .SB_query_rs2      (SB_query_rs2),
    .SB_rs1_busy       (SB_rs1_busy),
    .SB_rs2_busy       (SB_rs2_busy),
    .REG_write_address (REG_write_address),
    .REG_write_enable  (REG_write_enable),
    .REG_write_value   (REG_write_value),
    .LL_fifo_count     (LL_fifo_count)
  );

  always #5 SYS_clk = ~SYS_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        pv;  logic [4:0] prd; logic [31:0] pval;
    logic        iv;  logic [4:0] ird;
    logic        rv;  logic [4:0] rrd; logic [31:0] rval;
    logic [4:0]  q1;  logic [4:0] q2;
    logic        en;  logic [4:0] addr; logic [31:0] val;
    int          cnt; logic rdy; logic b1; logic b2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pval,
                       input logic iv, input logic [4:0] ird,
                       input logic rv, input logic [4:0] rrd, input logic [31:0] rval,
                       input logic [4:0] q1, input logic [4:0] q2);
    PIPE_wb_valid   = pv;  PIPE_wb_rd   = prd; PIPE_wb_value   = pval;
    LL_issue_valid  = iv;  LL_issue_rd  = ird;
    LL_result_valid = rv;  LL_result_rd = rrd; LL_result_value = rval;
    SB_query_rs1    = q1;  SB_query_rs2 = q2;
  endtask

  task automatic chk_outputs(input string tag, input logic en, input logic [4:0] addr,
                             input logic [31:0] val, input int cnt, input logic rdy,
                             input logic b1, input logic b2);
    chk({tag, ".en"},    32'(REG_write_enable),  32'(en));
    chk({tag, ".addr"},  32'(REG_write_address), 32'(addr));
    chk({tag, ".value"}, REG_write_value,        val);
    chk({tag, ".count"}, 32'(LL_fifo_count),     32'(cnt));
    chk({tag, ".ready"}, 32'(LL_result_ready),   32'(rdy));
    chk({tag, ".rs1"},   32'(SB_rs1_busy),       32'(b1));
    chk({tag, ".rs2"},   32'(SB_rs2_busy),       32'(b2));
  endtask

  vec_t vecs [16];

  // Reference model state
  ent_t        mq [$];
  logic [31:0] m_busy;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_val;
  int          m_commit_rd;

  initial begin
    // pv prd pval        iv ird rv rrd rval          q1 q2  en addr val          cnt rdy b1 b2
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b1, 5'd5,  32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b0, 5'd5,  32'hDEADBEEF, 0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b0, 5'd5,  32'hDEADBEEF, 0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7,  32'h12345678, 5'd7, 5'd10, 1'b0, 5'd5,  32'hDEADBEEF, 1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b1, 5'd7,  32'h12345678, 0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b0, 5'd7,  32'h12345678, 0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'd3, 32'h3,        1'b0, 5'd0, 1'b1, 5'd10, 32'hA0,       5'd7, 5'd10, 1'b1, 5'd3,  32'h3,        1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd3, 32'h4,        1'b0, 5'd0, 1'b1, 5'd11, 32'hA1,       5'd7, 5'd10, 1'b1, 5'd3,  32'h4,        2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd3, 32'h5,        1'b0, 5'd0, 1'b1, 5'd12, 32'hA2,       5'd7, 5'd10, 1'b1, 5'd3,  32'h5,        2, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b1, 5'd10, 32'hA0,       1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd0, 32'hBAD,      1'b0, 5'd0, 1'b1, 5'd13, 32'hA3,       5'd7, 5'd10, 1'b1, 5'd11, 32'hA1,       1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b1, 5'd13, 32'hA3,       0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b0, 5'd13, 32'hA3,       0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd0,  32'h55,       5'd7, 5'd10, 1'b0, 5'd13, 32'hA3,       1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b0, 5'd0,  32'h55,       0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd10, 1'b0, 5'd0,  32'h55,       0, 1'b1, 1'b0, 1'b0};

    // Reset state, then release mid-cycle
    SYS_reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd10);
    tick();
    tick();
    chk_outputs("reset", 1'b0, 5'd0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    SYS_reset = 1'b1;
    #1;
    chk("release.ready", 32'(LL_result_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pv, vecs[i].prd, vecs[i].pval, vecs[i].iv, vecs[i].ird,
            vecs[i].rv, vecs[i].rrd, vecs[i].rval, vecs[i].q1, vecs[i].q2);
      tick();
      chk_outputs($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].val,
                  vecs[i].cnt, vecs[i].rdy, vecs[i].b1, vecs[i].b2);
    end

    // Asynchronous reset with a full FIFO and busy bits pending
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0, 5'd20, 5'd21);
    tick();
    drive(1'b1, 5'd3, 32'h77, 1'b1, 5'd21, 1'b1, 5'd20, 32'hC0, 5'd20, 5'd21);
    tick();
    drive(1'b1, 5'd3, 32'h78, 1'b0, 5'd0, 1'b1, 5'd21, 32'hC1, 5'd20, 5'd21);
    tick();
    chk_outputs("prereset", 1'b1, 5'd3, 32'h78, 2, 1'b0, 1'b1, 1'b1);
    #2;
    SYS_reset = 1'b0;
    #1;
    chk_outputs("midreset", 1'b0, 5'd0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd21);
    tick();
    SYS_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outputs($sformatf("postreset%0d", i), 1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
    end

    // Randomized traffic against the reference model
    mq.delete();
    m_busy      = '0;
    m_en        = 1'b0;
    m_addr      = '0;
    m_val       = '0;
    m_commit_rd = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        pv, iv, rv, m_rdy;
      logic [4:0]  prd, ird, rrd, q1, q2;
      logic [31:0] pval, rval;
      int          pipe_pct, commit_now;
      ent_t        e;
      pipe_pct = ((cyc / 250) % 2 == 0) ? 80 : 30;
      pv   = ($urandom_range(99) < pipe_pct);
      prd  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      pval = $urandom;
      ird  = 5'($urandom);
      iv   = ($urandom_range(3) == 0) && !m_busy[ird];
      rv   = $urandom_range(1) == 1;
      rrd  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
      rval = $urandom;
      q1   = 5'($urandom);
      q2   = 5'($urandom);
      drive(pv, prd, pval, iv, ird, rv, rrd, rval, q1, q2);

      // Model: priority write selection, FIFO accept, commit-then-issue busy update
      m_rdy      = mq.size() < DEPTH;
      commit_now = m_commit_rd;
      m_commit_rd = -1;
      if (pv && prd != 0) begin
        m_en = 1'b1; m_addr = prd; m_val = pval;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = (e.rd != 0); m_addr = e.rd; m_val = e.val;
        m_commit_rd = int'(e.rd);
      end else begin
        m_en = 1'b0;
      end
      if (rv && m_rdy) mq.push_back('{rd: rrd, val: rval});
      if (commit_now >= 0) m_busy[commit_now] = 1'b0;
      if (iv) m_busy[ird] = 1'b1;
      m_busy[0] = 1'b0;

      tick();
      chk_outputs($sformatf("rnd%0d", cyc), m_en, m_addr, m_val, mq.size(),
                  mq.size() < DEPTH, m_busy[q1], m_busy[q2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
